// File: rtl/adc_spi_sequencer.sv
// Single-frame sequencer for an SPI ADC (AD7476 class): divides clk into SCLK, frames the
// conversion with cs_n, shifts miso in MSB-first and presents the low DATA_BITS of the frame
// with a one-cycle done strobe. Free-runs back to back while auto_en is held high.
module adc_spi_sequencer #(
  parameter int unsigned DIV_HALF   = 25,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned QUIET      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  localparam int unsigned QuietCycles = QUIET * DIV_HALF;
  // $clog2(1) is 0; keep at least one bit so DIV_HALF=1 still elaborates.
  localparam int unsigned DivW   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
  localparam int unsigned SetupW = $clog2(CS_SETUP + 1);
  localparam int unsigned QuietW = $clog2(QuietCycles + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

  state_e                state_q, state_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [SetupW-1:0]     setup_q, setup_d;
  logic [QuietW-1:0]     quiet_q, quiet_d;

  logic [FRAME_BITS-1:0] shift_next;
  logic                  div_tc;

  // The oldest frame bit falls off the top of the shifter and is never observed.
  logic unused_shift_msb;
  assign unused_shift_msb = shift_q[FRAME_BITS-1];

  // State and output registers; reset forces the bus idle and clears the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      setup_q <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      setup_q <= setup_d;
      quiet_q <= quiet_d;
    end
  end

  // Next-state logic: frame sequencing, SCLK division and MSB-first capture.
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_d     = data_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_d      = bit_q;
    setup_d    = setup_q;
    quiet_d    = quiet_q;
    shift_next = {shift_q[FRAME_BITS-2:0], miso};
    div_tc     = (div_q == DivW'(DIV_HALF - 1));

    case (state_q)
      StIdle: begin
        if (start || auto_en) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          setup_d = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (setup_q == SetupW'(CS_SETUP - 1)) begin
          state_d = StShift;
          div_d   = '0;
        end else begin
          setup_d = setup_q + SetupW'(1);
        end
      end
      StShift: begin
        if (div_tc) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Rising SCLK edge: capture miso on the same clk edge that raises SCLK.
          if (!sclk_q) begin
            shift_d = shift_next;
            bit_d   = bit_q + BitW'(1);
            if (bit_q == BitW'(FRAME_BITS - 1)) begin
              state_d = StQuiet;
              cs_n_d  = 1'b1;
              data_d  = shift_next[DATA_BITS-1:0];
              done_d  = 1'b1;
              quiet_d = '0;
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StQuiet: begin
        if (quiet_q == QuietW'(QuietCycles - 1)) begin
          quiet_d = '0;
          // Auto mode skips the idle cycle so busy never drops between frames.
          if (auto_en) begin
            state_d = StSetup;
            cs_n_d  = 1'b0;
            setup_d = '0;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          quiet_d = quiet_q + QuietW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sclk = sclk_q;
  assign cs_n = cs_n_q;
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule
